neuron_update_scheduler: RTL and testbench
==========================================

Name: neuron_update_scheduler

Overview:
Time-multiplexes one shared Izhikevich neuron datapath across NUM_NEURONS virtual neurons. On each timestep TICK it walks neuron indices 0..NUM_NEURONS-1 and skips neurons masked off by ENABLE_MASK. For each enabled neuron it issues a start to the datapath and waits for done. Spikes are queued in a small FIFO as index events for the NoC injection port.

Parameters:
NUM_NEURONS, 16, virtual neurons sharing the datapath
IDX_W, 4, index width; must satisfy 2**IDX_W >= NUM_NEURONS
FIFO_DEPTH, 4, spike-event FIFO entries (power of 2)
TS_W, 16, timestep counter width

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
TICK  in  1  single-cycle timestep start request
ENABLE_MASK  in  NUM_NEURONS  bit i=1 means neuron i is updated; sampled per index during scan
DP_START  out  1  one-cycle start pulse to datapath
DP_IDX  out  IDX_W  neuron index for datapath; held stable from DP_START until DP_DONE
DP_DONE  in  1  datapath update complete, single-cycle
DP_SPIKED  in  1  spike result; valid only with DP_DONE
SPIKE_VALID  out  1  FIFO head valid
SPIKE_IDX  out  IDX_W  FIFO head neuron index
SPIKE_TS  out  TS_W  timestep of FIFO head event
SPIKE_READY  in  1  consumer accepts the head when VALID&READY
BUSY  out  1  high in any state except IDLE
STEP_DONE  out  1  one-cycle pulse at end of timestep
TIMESTEP  out  TS_W  count of completed timesteps
OVERRUN  out  1  sticky: TICK arrived while BUSY

Behaviour:
- Reset (async assert, sync deassert-safe): state=IDLE, idx=0, TIMESTEP=0, FIFO empty. All outputs 0.
- FSM states: IDLE, SCAN, ISSUE, WAIT, HOLD, FINISH.
- IDLE: TICK=1 -> idx=0, go to SCAN next cycle. TICK in any other state is dropped and sets OVERRUN=1. OVERRUN clears only on reset.
- SCAN (one index per cycle):
  - ENABLE_MASK[idx]=1 -> ISSUE.
  - else idx==NUM_NEURONS-1 -> FINISH.
  - else idx++ and stay in SCAN.
- ISSUE: DP_START=1 for exactly this cycle, DP_IDX=idx -> WAIT.
- WAIT: stay until DP_DONE. On DP_DONE:
  - DP_SPIKED=1 and FIFO full -> HOLD, with the spike latched internally.
  - DP_SPIKED=1 and FIFO not full -> push {idx, TIMESTEP}.
  - After the push (or no spike): idx==last -> FINISH, else idx++ -> SCAN.
- HOLD: wait for a FIFO pop, then push the latched event in the cycle after the pop. Then advance as WAIT does.
- Simultaneous push and pop on a full FIFO is not allowed from WAIT: full means go to HOLD. On a non-full FIFO, same-cycle push and pop are both performed and occupancy is unchanged.
- FINISH: STEP_DONE=1 for one cycle, TIMESTEP++ (wraps modulo 2**TS_W) -> IDLE. STEP_DONE is not blocked by FIFO content.
- Minimum step latency with all neurons masked: TICK at cycle 0 -> STEP_DONE at cycle NUM_NEURONS+1.
- Per enabled neuron cost: 1 SCAN + 1 ISSUE + datapath latency.
- SPIKE_TS carries the TIMESTEP value before the FINISH increment.
- FIFO: first-word-fall-through. SPIKE_VALID = not empty. Pointers are IDX-independent, width log2(FIFO_DEPTH)+1.
- Spurious DP_DONE outside WAIT/HOLD is ignored.
- Reset mid-operation: in-flight update and FIFO contents are discarded, nothing is written back.

Decomposition:
- Shared package neuron_sched_pkg: FSM state encoding constants and default parameter values.
- One sub-module: spike_event_fifo (parameterised FWFT FIFO, data = {TS, IDX}, with full/empty outputs).

Test Plan:
1. All enabled, datapath model with DONE 3 cycles after START, no spikes; TICK at t0 -> 16 DP_START pulses with DP_IDX 0..15 in order, STEP_DONE once, TIMESTEP=1, FIFO stays empty.
2. ENABLE_MASK=16'h0000; TICK -> zero DP_START, STEP_DONE exactly 17 cycles after TICK. ENABLE_MASK=16'h8001 -> starts only for idx 0 and 15.
3. DP_SPIKED on idx 2, 5, 9; SPIKE_READY=1 -> events (2,0),(5,0),(9,0) appear in order. Second TICK with the same spikes -> SPIKE_TS=1.
4. SPIKE_READY=0, spikes on idx 0..5 -> FSM enters HOLD at idx 4 with BUSY high and no DP_START. Raising READY drains events 0..5 in order, none lost, then STEP_DONE.
5. TICK pulsed during BUSY -> OVERRUN=1 and remains set, step count unaffected. TIMESTEP preloaded near 16'hFFFF wraps to 0.
6. RESET_N asserted in WAIT with 2 FIFO entries -> all outputs 0 immediately (async). After release, a new TICK begins again at idx 0.

Source files
------------

// File: rtl/neuron_update_scheduler_pkg.sv
// neuron_update_scheduler_pkg: FSM state encoding and default sizing for the neuron update scheduler
package neuron_update_scheduler_pkg;
   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_HOLD, S_FINISH} state_t;
   localparam int NUM_NEURONS_DEF = 16;
   localparam int IDX_W_DEF = 4;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int TS_W_DEF = 16;
endpackage

// File: rtl/neuron_update_scheduler_if.sv
// neuron_update_scheduler_if: tick/mask control, datapath handshake and spike-event stream
interface neuron_update_scheduler_if
   import neuron_update_scheduler_pkg::*;
#(
   parameter int NUM_NEURONS = NUM_NEURONS_DEF,
   parameter int IDX_W = IDX_W_DEF,
   parameter int TS_W = TS_W_DEF
);
   logic tick;
   logic [NUM_NEURONS-1:0] enable_mask;
   logic dp_start;
   logic [IDX_W-1:0] dp_idx;
   logic dp_done;
   logic dp_spiked;
   logic spike_valid;
   logic [IDX_W-1:0] spike_idx;
   logic [TS_W-1:0] spike_ts;
   logic spike_ready;
   logic busy;
   logic step_done;
   logic [TS_W-1:0] timestep;
   logic overrun;
   modport slave (
      input tick, enable_mask, dp_done, dp_spiked, spike_ready,
      output dp_start, dp_idx, spike_valid, spike_idx, spike_ts, busy, step_done, timestep, overrun
   );
   modport master (
      output tick, enable_mask, dp_done, dp_spiked, spike_ready,
      input dp_start, dp_idx, spike_valid, spike_idx, spike_ts, busy, step_done, timestep, overrun
   );
endinterface

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: first-word-fall-through FIFO holding {timestep, index} spike events
module spike_event_fifo #(
   parameter int DW = 20,
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic [DW-1:0] din,
   input  logic pop,
   output logic [DW-1:0] dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   logic [DW-1:0] mem [DEPTH];
   logic [AW:0] wr, rd;
   // extra pointer bit tells full from empty when the addresses coincide
   assign empty = wr == rd;
   assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
   assign dout = mem[rd[AW-1:0]];
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr[AW-1:0]] <= din;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr <= '0;
         rd <= '0;
      end else begin
         if (push && !full) wr <= wr + (AW+1)'(1);
         if (pop && !empty) rd <= rd + (AW+1)'(1);
      end
   end
endmodule

// File: rtl/neuron_update_scheduler.sv
// neuron_update_scheduler: walks enabled virtual neurons through one shared datapath per timestep
module neuron_update_scheduler
   import neuron_update_scheduler_pkg::*;
#(
   parameter int NUM_NEURONS = NUM_NEURONS_DEF,
   parameter int IDX_W = IDX_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int TS_W = TS_W_DEF
) (
   input logic clk,
   input logic rst_n,
   neuron_update_scheduler_if.slave bus
);
   state_t state;
   logic [IDX_W-1:0] idx;
   logic [TS_W-1:0] ts;
   logic dp_start, step_done, overrun;
   logic push, pop, full, empty, last, enabled, stall, advance;
   logic [TS_W+IDX_W-1:0] head;
   assign last = idx == IDX_W'(NUM_NEURONS - 1);
   assign enabled = bus.enable_mask[idx];
   assign pop = !empty && bus.spike_ready;
   // a spike that meets a full FIFO parks in HOLD; the event is still {ts, idx}
   assign stall = state == S_WAIT && bus.dp_done && bus.dp_spiked && full;
   assign advance = (state == S_WAIT && bus.dp_done && !stall) || (state == S_HOLD && !full);
   assign push = advance && (state == S_HOLD || bus.dp_spiked);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         idx <= '0;
         ts <= '0;
         dp_start <= 1'b0;
         step_done <= 1'b0;
         overrun <= 1'b0;
      end else begin
         dp_start <= state == S_SCAN && enabled;
         step_done <= last && ((state == S_SCAN && !enabled) || advance);
         if (bus.tick && state != S_IDLE) overrun <= 1'b1;
         case (state)
            S_IDLE: if (bus.tick) begin
               idx <= '0;
               state <= S_SCAN;
            end
            S_SCAN: if (enabled) state <= S_ISSUE;
               else if (last) state <= S_FINISH;
               else idx <= idx + IDX_W'(1);
            S_ISSUE: state <= S_WAIT;
            S_WAIT, S_HOLD: if (stall) state <= S_HOLD;
               else if (advance) begin
                  state <= last ? S_FINISH : S_SCAN;
                  if (!last) idx <= idx + IDX_W'(1);
               end
            S_FINISH: begin
               ts <= ts + TS_W'(1);
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
   spike_event_fifo #(.DW(TS_W + IDX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(push),
      .din({ts, idx}),
      .pop(pop),
      .dout(head),
      .full(full),
      .empty(empty)
   );
   assign bus.dp_start = dp_start;
   assign bus.dp_idx = idx;
   assign bus.busy = state != S_IDLE;
   assign bus.step_done = step_done;
   assign bus.timestep = ts;
   assign bus.overrun = overrun;
   assign bus.spike_valid = !empty;
   assign {bus.spike_ts, bus.spike_idx} = empty ? '0 : head;
endmodule

// File: tb/tb_neuron_update_scheduler.sv
// tb_neuron_update_scheduler: directed and randomized timesteps checked against an index-list model
module tb_neuron_update_scheduler;
   localparam int N = 16;
   localparam int IW = 4;
   localparam int TW = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   neuron_update_scheduler_if #(.NUM_NEURONS(N), .IDX_W(IW), .TS_W(TW)) bus ();
   neuron_update_scheduler #(.NUM_NEURONS(N), .IDX_W(IW), .FIFO_DEPTH(4), .TS_W(TW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   int errors = 0, checks = 0, cyc = 0, steps = 0, done_cyc = 0;
   int lat_fix = 3, ready_mode = 1, n0 = 0, t0 = 0, rk = 0, rlat = 0;
   logic [N-1:0] spike_set = '0, cur_mask = '0;
   logic [TW-1:0] exp_ts = '0;
   int starts[$];
   logic [TW+IW-1:0] events[$];

   initial forever begin
      @(posedge clk);
      cyc++;
   end
   initial forever begin
      @(negedge clk);
      if (bus.step_done) begin
         steps++;
         done_cyc = cyc;
      end
      if (bus.spike_valid && bus.spike_ready) events.push_back({bus.spike_ts, bus.spike_idx});
   end
   // datapath model: done (with the neuron's spike bit) a chosen number of cycles after start
   initial begin
      bus.dp_done = 1'b0;
      bus.dp_spiked = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.dp_start) begin
            rk = int'(bus.dp_idx);
            starts.push_back(rk);
            rlat = lat_fix != 0 ? lat_fix : int'($urandom_range(1, 5));
            repeat (rlat) @(posedge clk);
            #1 bus.dp_done = 1'b1;
            bus.dp_spiked = spike_set[rk];
            @(posedge clk);
            #1 bus.dp_done = 1'b0;
            bus.dp_spiked = 1'b0;
         end
      end
   end
   initial begin
      bus.spike_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 bus.spike_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic start_step(input logic [N-1:0] m, input logic [N-1:0] s, input int rm);
      starts.delete();
      events.delete();
      cur_mask = m;
      spike_set = s;
      ready_mode = rm;
      @(posedge clk);
      #1 bus.enable_mask = m;
      bus.tick = 1'b1;
      t0 = cyc;
      n0 = steps;
      @(posedge clk);
      #1 bus.tick = 1'b0;
   endtask

   // expected: every enabled index in ascending order, spiking ones stamped with this step's timestep
   task automatic finish_step(input string tag);
      int exp_st[$];
      logic [TW+IW-1:0] exp_ev[$];
      for (int i = 0; i < 4000 && steps == n0; i++) @(negedge clk);
      ready_mode = 1;
      for (int i = 0; i < 200 && bus.spike_valid; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk({tag, ".steps"}, steps - n0, 1);
      for (int i = 0; i < N; i++) begin
         if (cur_mask[i]) begin
            exp_st.push_back(i);
            if (spike_set[i]) exp_ev.push_back({exp_ts, IW'(i)});
         end
      end
      chk({tag, ".n_starts"}, starts.size(), exp_st.size());
      for (int i = 0; i < exp_st.size() && i < starts.size(); i++)
         chk($sformatf("%s.start%0d", tag, i), starts[i], exp_st[i]);
      chk({tag, ".n_events"}, events.size(), exp_ev.size());
      for (int i = 0; i < exp_ev.size() && i < events.size(); i++)
         chk($sformatf("%s.event%0d", tag, i), 32'(events[i]), 32'(exp_ev[i]));
      exp_ts++;
      chk({tag, ".timestep"}, bus.timestep, exp_ts);
      chk({tag, ".busy"}, bus.busy, 0);
   endtask

   initial begin
      bus.tick = 1'b0;
      bus.enable_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", bus.busy, 0);
      chk("rst.dp_start", bus.dp_start, 0);
      chk("rst.dp_idx", bus.dp_idx, 0);
      chk("rst.valid", bus.spike_valid, 0);
      chk("rst.spike_idx", bus.spike_idx, 0);
      chk("rst.spike_ts", bus.spike_ts, 0);
      chk("rst.step_done", bus.step_done, 0);
      chk("rst.timestep", bus.timestep, 0);
      chk("rst.overrun", bus.overrun, 0);
      rst_n = 1'b1;
      lat_fix = 3;
      start_step(16'hFFFF, 16'h0000, 1);
      finish_step("all_on");
      start_step(16'h0000, 16'h0000, 1);
      finish_step("all_off");
      chk("all_off.latency", done_cyc - t0, N + 1);
      start_step(16'h8001, 16'h0000, 1);
      finish_step("ends");
      start_step(16'hFFFF, 16'h0224, 1);
      finish_step("spk_a");
      start_step(16'hFFFF, 16'h0224, 1);
      finish_step("spk_b");
      start_step(16'hFFFF, 16'h003F, 0);
      for (int i = 0; i < 500 && starts.size() < 5; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      chk("hold.n_starts", starts.size(), 5);
      chk("hold.busy", bus.busy, 1);
      chk("hold.dp_start", bus.dp_start, 0);
      chk("hold.valid", bus.spike_valid, 1);
      chk("hold.head_idx", bus.spike_idx, 0);
      chk("hold.head_ts", bus.spike_ts, exp_ts);
      ready_mode = 1;
      finish_step("hold");
      chk("ovr.pre", bus.overrun, 0);
      start_step(16'hFFFF, 16'h0000, 1);
      repeat (10) @(posedge clk);
      #1 bus.tick = 1'b1;
      @(posedge clk);
      #1 bus.tick = 1'b0;
      @(negedge clk);
      chk("ovr.set", bus.overrun, 1);
      finish_step("ovr");
      start_step(16'h00F0, 16'h0000, 1);
      finish_step("ovr_next");
      chk("ovr.sticky", bus.overrun, 1);
      lat_fix = 0;
      for (int r = 0; r < 20; r++) begin
         start_step(16'($urandom), 16'($urandom), 2);
         finish_step($sformatf("rnd%0d", r));
      end
      lat_fix = 8;
      start_step(16'hFFFF, 16'h0003, 0);
      for (int i = 0; i < 500 && starts.size() < 3; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("mid.busy", bus.busy, 1);
      chk("mid.valid", bus.spike_valid, 1);
      chk("mid.head_idx", bus.spike_idx, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst.busy", bus.busy, 0);
      chk("arst.valid", bus.spike_valid, 0);
      chk("arst.spike_idx", bus.spike_idx, 0);
      chk("arst.spike_ts", bus.spike_ts, 0);
      chk("arst.dp_start", bus.dp_start, 0);
      chk("arst.dp_idx", bus.dp_idx, 0);
      chk("arst.timestep", bus.timestep, 0);
      chk("arst.overrun", bus.overrun, 0);
      repeat (12) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_ts = '0;
      lat_fix = 3;
      start_step(16'hFFFF, 16'h0010, 1);
      finish_step("post_rst");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
